// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit of the multicycle MIPS
// datapath: the controller state encoding, the operation selector and the
// default operand width and iteration count.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's-complement negation.
// Used to turn the signed operands into unsigned magnitudes and to apply the
// latched result signs to the product, quotient and remainder.
//   i_val  WIDTH  input value
//   i_neg  1      negate when high
//   o_val  WIDTH  i_neg ? -i_val : i_val
module abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  always_comb begin
    o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiplier / divider producing HI and LO for the
// mfhi/mflo write-back path. Multiply is shift-add and divide is restoring
// division, both on unsigned magnitudes and sharing one accumulator and one
// (WIDTH+1)-bit adder; signs are applied in a final SIGN step.
//   clk          1      rising-edge clock
//   reset        1      synchronous, active-high
//   start_mult   1      one-cycle request: signed a*b
//   start_div    1      one-cycle request: signed a/b
//   a, b         WIDTH  operands
//   hi, lo       WIDTH  product[2W-1:W]/product[W-1:0] or remainder/quotient
//   busy         1      high whenever the controller is not idle
//   done         1      one-cycle pulse when hi/lo have just been updated
//   div_by_zero  1      set by a divide with b==0, cleared by the next start
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;       // {hi-half, lo-half} or {rem, quot}
  logic               r_sign_pq;   // product / quotient sign
  logic               r_sign_r;    // remainder sign
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_accept;
  logic               w_sel_mult;
  logic               w_b_zero;
  logic               w_dbz;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_shl;
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes; 0x80..0 maps to unsigned 2^(WIDTH-1) without overflow.
  abs_neg #(.WIDTH(WIDTH)) u_abs_a (.i_val(a), .i_neg(a[WIDTH-1]), .o_val(w_mag_a));
  abs_neg #(.WIDTH(WIDTH)) u_abs_b (.i_val(b), .i_neg(b[WIDTH-1]), .o_val(w_mag_b));

  // Result sign fix-up: full-width product, independent quotient/remainder.
  abs_neg #(.WIDTH(2*WIDTH)) u_neg_p (.i_val(r_acc), .i_neg(r_sign_pq), .o_val(w_prod));
  abs_neg #(.WIDTH(WIDTH)) u_neg_q (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_sign_pq), .o_val(w_quot));
  abs_neg #(.WIDTH(WIDTH)) u_neg_r (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_sign_r), .o_val(w_rem));

  always_comb begin
    w_accept   = (r_state == IDLE) && (start_mult || start_div);
    w_sel_mult = start_mult;
    w_b_zero   = (b == '0);
    w_dbz      = !start_mult && start_div && w_b_zero;
  end

  // Shared adder: multiply adds the multiplicand into the upper half;
  // divide subtracts the divisor from the shifted remainder as A + ~B + 1,
  // so the top bit of the (WIDTH+1)-bit sum flags a negative trial result.
  always_comb begin
    w_shl   = {r_acc[2*WIDTH-2:0], 1'b0};
    w_add_a = '0;
    w_add_b = '0;
    w_cin   = 1'b0;
    if (r_op == OP_MULT) begin
      w_add_a = r_acc[2*WIDTH-1:WIDTH];
      w_add_b = {1'b0, r_opnd};
      w_cin   = 1'b0;
    end else begin
      w_add_a = w_shl[2*WIDTH-1:WIDTH];
      w_add_b = ~{1'b0, r_opnd};
      w_cin   = 1'b1;
    end
    w_sum = {1'b0, w_add_a} + w_add_b + (WIDTH+1)'(w_cin);

    w_step = r_acc;
    if (r_op == OP_MULT) begin
      if (r_acc[0]) begin
        w_step = {w_sum, r_acc[WIDTH-1:1]};
      end else begin
        w_step = {1'b0, r_acc[2*WIDTH-1:1]};
      end
    end else begin
      if (w_sum[WIDTH]) begin
        w_step = w_shl;
      end else begin
        w_step = {w_sum[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_dbz ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CW'(ITER - 1)) begin
          w_next = SIGN;
        end
      end
      SIGN: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_MULT;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_sign_pq <= 1'b0;
      r_sign_r  <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= w_sel_mult ? OP_MULT : OP_DIV;
            r_sign_pq <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r  <= a[WIDTH-1];
            r_cnt     <= '0;
            r_dbz     <= w_dbz;
            if (w_sel_mult) begin
              r_opnd <= w_mag_a;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            end else begin
              r_opnd <= w_mag_b;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            end
          end
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        SIGN: begin
          if (r_op == OP_MULT) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hi          = r_hi;
    lo          = r_lo;
    div_by_zero = r_dbz;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed 32x32 multiplier and 32/32 divider for the multicycle MIPS datapath (mult, div).
- Produces HI/LO, which feed the register-write data selection mux as two of its 32-bit inputs (mfhi/mflo path).
- The control unit starts an operation with a one-cycle start pulse and waits on busy/done; the multiplier and divider share one shift datapath.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration count, equal to WIDTH; sizes the iteration counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start_mult  input  1  one-cycle request: signed multiply a*b
- start_div  input  1  one-cycle request: signed divide a/b
- a  input  WIDTH  operand A (multiplicand or dividend)
- b  input  WIDTH  operand B (multiplier or divisor)
- hi  output  WIDTH  HI register: product[63:32] or remainder
- lo  output  WIDTH  LO register: product[31:0] or quotient
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse when hi/lo have just been updated
- div_by_zero  output  1  registered flag; set by a div with b==0, cleared by the next accepted start

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - State goes to IDLE and the counter clears.
  - Reset mid-operation aborts the operation and discards partial results.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - Start is sampled at edge N. start_mult has priority if both starts are high.
  - On accept:
    - Latch the operand magnitudes |a| and |b|.
    - Latch the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
    - Set counter=0 and go to CALC.
  - Div with b==0:
    - No CALC; go straight to DONE at edge N.
    - div_by_zero=1; hi/lo keep their previous values.
- CALC:
  - One iteration per edge, N+1 through N+32. Go to SIGN when counter==ITER-1.
  - Multiply: shift-add on a 64-bit accumulator. If the multiplier LSB is 1, add the multiplicand into the upper half, then shift right one bit.
  - Divide: restoring division. Shift {rem,quot} left one bit, trial-subtract the divisor from rem; if non-negative, keep the result and set quot[0]=1.
  - All arithmetic is unsigned on the magnitudes; the carry out of the adder is captured (33-bit add).
- SIGN (edge N+33):
  - Apply two's-complement negation per the latched signs: 64-bit negation for the product; independent 32-bit negations for quotient and remainder.
  - Load hi/lo and go to DONE.
- DONE:
  - done=1 for exactly one cycle; hi/lo are valid from the same cycle.
  - Next edge returns to IDLE; busy drops in that cycle.
- Latency: start at edge N gives done high in the cycle after edge N+33, and busy low after edge N+34.
- Starts while busy=1 are ignored, with no queuing.
- Edge cases:
  - 0x80000000 magnitude is represented as unsigned 2^31 without overflow.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- hi and lo change only at SIGN or at reset, and stay stable otherwise.

Decomposition:
- Shared package (mips_pkg): state enum (IDLE, CALC, SIGN, DONE), WIDTH/ITER constants, op encoding (OP_MULT, OP_DIV).
- Sub-module: none for the FSM. Optionally, one small combinational helper, abs_neg (conditional two's-complement), instantiated for the operand magnitudes and the sign fix.

Test Plan:
- mult, a=7, b=0xFFFFFFFD (-3) -> done after 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 34 cycles.
- mult, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then div 100/7 -> lo=14, hi=2.
- div, b=0 with prior hi=0x12, lo=0x34 -> done one cycle after start, div_by_zero=1, hi/lo unchanged. Next mult clears div_by_zero.
- Start mult, pulse start_div at cycle 10, then reset at cycle 20 -> start_div ignored; after reset, hi=lo=0, busy=0, done=0; a new start works normally.
- start_mult and start_div high together, a=5, b=3 -> multiply performed, lo=15, hi=0.
